// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per cycle over 32 cycles, sharing a single 33-bit adder.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [4:0]         cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   result_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     add_a_s;
    logic [WIDTH:0]     add_b_s;
    logic               add_cin_s;
    logic [WIDTH+1:0]   add_res_s;
    logic [WIDTH-1:0]   hi_nxt_s;
    logic [WIDTH-1:0]   lo_nxt_s;
    logic [WIDTH-1:0]   res_sel_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == 5'd31) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One iteration: the adder either accumulates the multiplicand or trial-subtracts the divisor.
    // For divide, the adder's carry-out is the "remainder >= divisor" flag (subtract as add of ~b + 1).
    always_comb begin
        rem_sh_s = {hi_r, lo_r[WIDTH-1]};
        if (op_r[1]) begin
            add_a_s   = rem_sh_s;
            add_b_s   = ~{1'b0, opb_r};
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = {1'b0, hi_r};
            add_b_s   = lo_r[0] ? {1'b0, opb_r} : '0;
            add_cin_s = 1'b0;
        end
        add_res_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH+1){1'b0}}, add_cin_s};
        if (op_r[1]) begin
            hi_nxt_s = add_res_s[WIDTH+1] ? add_res_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], add_res_s[WIDTH+1]};
        end else begin
            hi_nxt_s = add_res_s[WIDTH:1];
            lo_nxt_s = {add_res_s[0], lo_r[WIDTH-1:1]};
        end
        case (op_r)
            2'b00:   res_sel_s = lo_nxt_s;
            2'b01:   res_sel_s = hi_nxt_s;
            2'b10:   res_sel_s = lo_nxt_s;
            2'b11:   res_sel_s = hi_nxt_s;
            default: res_sel_s = '0;
        endcase
    end

    // State, operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 5'd0;
            op_r     <= 2'b00;
            opb_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                op_r  <= op;
                opb_r <= srcb;
                hi_r  <= '0;
                lo_r  <= srca;
                cnt_r <= 5'd0;
            end else if (state_r == ST_RUN) begin
                hi_r  <= hi_nxt_s;
                lo_r  <= lo_nxt_s;
                cnt_r <= cnt_r + 5'd1;
                if (cnt_r == 5'd31) begin
                    result_r <= res_sel_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return prod[31:0];
            2'b01:   return prod[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Drive a request, step past the accepting edge, then scramble the inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        srca  = $urandom;
        srcb  = $urandom;
        check_val("accept_busy", {63'd0, busy}, 64'd1);
    endtask

    // Wait for done, checking latency, busy throughout RUN and the delivered result.
    task automatic collect(input string tag, input logic [31:0] exp, input bit glitch);
        int cyc;
        int busy_bad;
        cyc      = 0;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_bad++;
            if (glitch && cyc == 5) begin
                start = 1'b1;
                op    = 2'($urandom);
                srca  = $urandom;
                srcb  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_val({tag, "_latency"}, 64'(cyc), 64'd32);
        check_val({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
        check_val({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_result"}, {32'd0, result}, {32'd0, exp});
    endtask

    // Idle cycle after DONE: pulse ends and result holds.
    task automatic after_done(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_val({tag, "_hold"}, {32'd0, result}, {32'd0, exp});
    endtask

    task automatic one_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        e = ref_model(o, a, b);
        issue(o, a, b);
        collect(tag, e, 1'b0);
        after_done(tag, e);
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int          done_seen;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srca  = 32'd0;
        srcb  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_result", {32'd0, result}, 64'd0);
        reset = 1'b0;

        one_op("mul7x6", 2'b00, 32'd7, 32'd6);
        check_val("mul7x6_const", {32'd0, result}, 64'h2A);
        one_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("mul_ff_const", {32'd0, result}, 64'h1);
        one_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("mulhu_ff_const", {32'd0, result}, 64'hFFFF_FFFE);
        one_op("divu100_7", 2'b10, 32'd100, 32'd7);
        check_val("divu100_7_const", {32'd0, result}, 64'hE);
        one_op("remu100_7", 2'b11, 32'd100, 32'd7);
        check_val("remu100_7_const", {32'd0, result}, 64'h2);
        one_op("divu_msb", 2'b10, 32'h8000_0000, 32'd1);
        check_val("divu_msb_const", {32'd0, result}, 64'h8000_0000);
        one_op("divu_by0", 2'b10, 32'd5, 32'd0);
        check_val("divu_by0_const", {32'd0, result}, 64'hFFFF_FFFF);
        one_op("remu_by0", 2'b11, 32'd5, 32'd0);
        check_val("remu_by0_const", {32'd0, result}, 64'h5);

        // start pulsed mid-run with new operands must be ignored
        issue(2'b00, 32'd1234, 32'd5678);
        collect("glitch", ref_model(2'b00, 32'd1234, 32'd5678), 1'b1);
        after_done("glitch", ref_model(2'b00, 32'd1234, 32'd5678));

        // back-to-back: next request issued during the DONE cycle
        issue(2'b10, 32'd1000, 32'd3);
        collect("b2b_first", 32'd333, 1'b0);
        issue(2'b11, 32'd1000, 32'd3);
        collect("b2b_second", 32'd1, 1'b0);
        after_done("b2b_second", 32'd1);

        // reset in the middle of RUN aborts without a done pulse
        issue(2'b00, 32'd99, 32'd77);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("midrst_busy", {63'd0, busy}, 64'd0);
        check_val("midrst_done", {63'd0, done}, 64'd0);
        check_val("midrst_result", {32'd0, result}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check_val("midrst_no_done", 64'(done_seen), 64'd0);
        one_op("mul3x4", 2'b00, 32'd3, 32'd4);
        check_val("mul3x4_const", {32'd0, result}, 64'hC);

        // random operations, with a divide-by-zero every few
        for (int k = 0; k < 40; k++) begin
            o = 2'($urandom);
            a = $urandom;
            b = (k % 7 == 3) ? 32'd0 : ((k % 5 == 1) ? 32'($urandom_range(1, 255)) : $urandom);
            e = ref_model(o, a, b);
            issue(o, a, b);
            collect("rand", e, (k % 4 == 2));
            if (k % 3 == 0) begin
                after_done("rand", e);
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 start  input  1  request to begin an operation.
REQ-005 op  input  2  00=MUL (low 32 of product), 01=MULHU (high 32), 10=DIVU (quotient), 11=REMU (remainder); all unsigned.
REQ-006 srca  input  32  multiplicand / dividend.
REQ-007 srcb  input  32  multiplier / divisor.
REQ-008 busy  output  1  high while an operation iterates.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 result  output  32  operation result.

Function
REQ-011 States SHALL be IDLE, RUN, DONE; encoding is free.
REQ-012 Accept: start=1 at an edge in IDLE or DONE SHALL capture srca, srcb, op, clear the iteration counter and enter RUN.
REQ-013 start while in RUN SHALL be ignored; srca/srcb/op changes during RUN SHALL NOT affect the result.
REQ-014 RUN SHALL last exactly 32 cycles (counter 0..31, one iteration per cycle), then enter DONE.
REQ-015 busy SHALL equal 1 exactly in RUN; done SHALL equal 1 exactly in DONE.
REQ-016 DONE SHALL last one cycle; with no start it returns to IDLE; with start it accepts per REQ-012 (back-to-back).
REQ-017 Latency: accept at edge E0 -> busy high cycles E0..E31, done high in cycle after edge E32.
REQ-018 result SHALL update only on the transition RUN->DONE and hold until the next such transition or reset.
REQ-019 Multiply SHALL be shift-add: per iteration, add srcb to upper accumulator half if current multiplier LSB=1 (33-bit sum), then shift 65-bit {carry,acc} right by one.
REQ-020 Divide SHALL be restoring: per iteration, shift {rem,quot} left one, trial-subtract divisor from 33-bit rem, keep difference and set quotient bit if non-negative, else restore.
REQ-021 Datapath SHALL use one 33-bit add/subtract per cycle; no multiply, divide or modulo operators.
REQ-022 DIVU with srcb=0 SHALL give 0xFFFFFFFF; REMU with srcb=0 SHALL give srca; still 32 RUN cycles, no special path required beyond REQ-020.
REQ-023 MUL and MULHU of same operands SHALL return the low/high halves of the same 64-bit product.

Reset
REQ-024 reset=1 SHALL force IDLE, busy=0, done=0, result=0, counter=0, regardless of state.
REQ-025 reset mid-RUN SHALL abort the operation without a done pulse; reset has priority over start.
REQ-026 First start after reset deassertion SHALL be accepted normally.

Verification
REQ-027 MUL 7 x 6: accept at E0 -> busy 32 cycles, done one cycle after E32, result 0x0000002A.
REQ-028 MUL and MULHU of 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE respectively.
REQ-029 DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 0x80000000/1 -> 0x80000000.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; 32-cycle latency unchanged.
REQ-031 start pulsed with new operands at RUN iteration 5 -> ignored, original result delivered; start asserted in DONE cycle -> new op accepted, busy high next cycle, no idle gap.
REQ-032 reset asserted at RUN iteration 10 -> next cycle busy=0, done=0, result=0; no done pulse follows; subsequent MUL 3 x 4 -> 0x0000000C.
